mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Sole master of the unified 4-cycle-latency main memory. Arbitrates I-cache block fills, D-cache block
//  fills and D-cache write-through stores, sequences the per-word read bursts, and steers returning data
//  and data/tag write enables to the owning cache. Sits between both caches' tag-match logic and memory.
// PARAMETERS
//  WORDS_PER_BLK  8   16-bit words per cache block (block = 16 bytes, byte addressed)
//  MEM_LAT        4   cycles from read issue (mem_en=1, mem_wr=0) to mem_data_valid for that word
//  AW             16  address width; DW 16 data width
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous reset, active-high
//  i_miss_req     in   1   I-cache miss pending (level, held until block present)
//  i_miss_addr    in   AW  I-cache miss byte address
//  d_miss_req     in   1   D-cache miss pending (level)
//  d_miss_addr    in   AW  D-cache miss byte address
//  st_req         in   1   D-side write-through store pending (level)
//  st_addr        in   AW  store byte address;  st_data  in  DW  store data
//  st_ack         out  1   one-cycle pulse: store written to memory this cycle
//  i_stall        out  1   stall fetch;  d_stall  out  1   stall memory stage
//  i_fill_we      out  1   write fill_data into I data array at fill_word
//  i_tag_we       out  1   write I tag array (last word of block)
//  d_fill_we      out  1   as i_fill_we for D-cache;  d_tag_we  out  1   as i_tag_we for D-cache
//  fill_word      out  3   word index within block for the current fill write
//  fill_data      out  DW  = mem_data_in (pass-through)
//  mem_en         out  1   memory enable;  mem_wr  out  1   1=write, 0=read
//  mem_addr       out  AW  memory byte address;  mem_wdata  out  DW  = st_data when writing
//  mem_data_valid in   1   memory read data valid;  mem_data_in  in  DW  memory read data
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, owner=I, last_fill=D, issue_cnt=0, ret_cnt=0; all outputs 0 except busy=0.
//  States: IDLE, FILL (issuing reads), DRAIN (all reads issued, awaiting returns), WRITE (one store).
//  IDLE grant, evaluated every cycle, registered into state on next edge:
//   - both i_miss_req & d_miss_req: grant the one that is NOT last_fill (alternation, no starvation);
//   - else the single pending miss; else st_req -> WRITE; else stay IDLE.
//   - misses always beat st_req; a store waits until no miss is pending in IDLE.
//  Grant latches owner and base = miss_addr & ~(2*WORDS_PER_BLK-1); updates last_fill.
//  FILL: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt, one read per cycle; issue_cnt++ ;
//   after WORDS_PER_BLK issues -> DRAIN. Reads of issue k return exactly MEM_LAT cycles later.
//  FILL/DRAIN: on mem_data_valid: owner's fill_we=1, fill_word=ret_cnt, ret_cnt++;
//   on the return with ret_cnt==WORDS_PER_BLK-1 also owner's tag_we=1 and next state IDLE.
//  Fill timing: grant edge T; reads issued T+1..T+8; fill_we T+5..T+12; tag_we at T+12; IDLE at T+13.
//  WRITE: exactly one cycle: mem_en=1, mem_wr=1, mem_addr=st_addr, mem_wdata=st_data, st_ack=1 -> IDLE.
//  Non-owner fill_we/tag_we always 0. mem_data_valid in IDLE or WRITE is ignored (no counting, no we).
//  Stall: i_stall = i_miss_req | (busy & owner==I & state!=WRITE);
//         d_stall = d_miss_req | (st_req & ~st_ack) | (busy & owner==D & state!=WRITE).
//  Requester dropping req mid-fill does not abort: fill completes to the latched owner.
//  Counters are 3-bit plus done flag; wrap of fill_word never occurs within a block.
//  rst mid-operation: immediate return to IDLE, counters cleared, in-flight returns ignored.
// TESTING
//  1 I miss 0x1236 alone -> reads 0x1230..0x123E T+1..T+8; i_fill_we words 0..7 T+5..T+12; i_tag_we T+12.
//  2 I and D miss same cycle after reset (last_fill=D) -> I fills first, then D fill starts next IDLE cycle.
//  3 I miss held continuously while D miss pending -> fills alternate I,D,I; D never starved.
//  4 st_req 0x0040/0xBEEF in IDLE, no misses -> mem_wr=1 addr 0x0040 data 0xBEEF, st_ack one cycle later only.
//  5 st_req + d_miss_req together -> D fill completes first, store issued in cycle after IDLE re-entry.
//  6 rst asserted at T+7 of a fill -> IDLE next edge, no fill_we/tag_we from late returns, busy=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the two caches' miss/store logic and main memory.
// master = arbiter side, slave = cache/memory environment side.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          i_miss_req;
  logic [AW-1:0] i_miss_addr;
  logic          d_miss_req;
  logic [AW-1:0] d_miss_addr;
  logic          st_req;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ack;
  logic          i_stall;
  logic          d_stall;
  logic          i_fill_we;
  logic          i_tag_we;
  logic          d_fill_we;
  logic          d_tag_we;
  logic [2:0]    fill_word;
  logic [DW-1:0] fill_data;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_data_valid;
  logic [DW-1:0] mem_data_in;
  logic          busy;

  modport master (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    input  st_req, st_addr, st_data, mem_data_valid, mem_data_in,
    output st_ack, i_stall, d_stall, i_fill_we, i_tag_we, d_fill_we, d_tag_we,
    output fill_word, fill_data, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport slave (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    output st_req, st_addr, st_data, mem_data_valid, mem_data_in,
    input  st_ack, i_stall, d_stall, i_fill_we, i_tag_we, d_fill_we, d_tag_we,
    input  fill_word, fill_data, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter: alternating I/D block fills, write-through stores behind misses,
// registered memory commands and pass-through fill data steered to the owning cache.
module mem_port_arbiter #(
  parameter int WORDS_PER_BLK = 8,
  parameter int AW            = 16,
  parameter int DW            = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int              CW        = $clog2(WORDS_PER_BLK);
  localparam logic [CW-1:0]   LAST_WORD = CW'(WORDS_PER_BLK - 1);
  localparam logic [AW-1:0]   BLK_MASK  = AW'(2 * WORDS_PER_BLK - 1);
  localparam logic            OWNER_I   = 1'b0;
  localparam logic            OWNER_D   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          owner_r, owner_s;
  logic          last_fill_r, last_fill_s;
  logic [AW-1:0] base_r, base_s;
  logic [CW-1:0] issue_cnt_r, issue_cnt_s;
  logic [CW-1:0] ret_cnt_r, ret_cnt_s;
  logic          mem_en_r, mem_en_s;
  logic          mem_wr_r, mem_wr_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s;
  logic          st_ack_r, st_ack_s;
  logic          ret_s, last_ret_s, busy_s;
  logic          pick_s, take_s;

  // Returns outside FILL/DRAIN (idle, store, after a reset) are dropped here.
  assign ret_s      = ((state_r == FILL) || (state_r == DRAIN)) && bus.mem_data_valid;
  assign last_ret_s = ret_s && (ret_cnt_r == LAST_WORD);
  assign busy_s     = (state_r != IDLE);

  // Next-state, counters and the memory command for the following cycle.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_fill_s = last_fill_r;
    base_s      = base_r;
    issue_cnt_s = issue_cnt_r;
    ret_cnt_s   = ret_cnt_r;
    mem_en_s    = 1'b0;
    mem_wr_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    st_ack_s    = 1'b0;
    pick_s      = owner_r;
    take_s      = 1'b0;

    case (state_r)
      IDLE: begin
        issue_cnt_s = '0;
        ret_cnt_s   = '0;
        // On a tie the side that did not fill last wins, so neither cache starves.
        if (bus.i_miss_req && bus.d_miss_req) begin
          take_s = 1'b1;
          pick_s = ~last_fill_r;
        end else if (bus.i_miss_req) begin
          take_s = 1'b1;
          pick_s = OWNER_I;
        end else if (bus.d_miss_req) begin
          take_s = 1'b1;
          pick_s = OWNER_D;
        end else begin
          take_s = 1'b0;
          pick_s = owner_r;
        end

        if (take_s) begin
          state_s     = FILL;
          owner_s     = pick_s;
          last_fill_s = pick_s;
          base_s      = (pick_s == OWNER_D) ? (bus.d_miss_addr & ~BLK_MASK)
                                            : (bus.i_miss_addr & ~BLK_MASK);
        end else if (bus.st_req && !st_ack_r) begin
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        mem_en_s    = 1'b1;
        mem_addr_s  = base_r + AW'({issue_cnt_r, 1'b0});
        issue_cnt_s = issue_cnt_r + CW'(1);
        if (issue_cnt_r == LAST_WORD) begin
          state_s = DRAIN;
        end else begin
          state_s = FILL;
        end
      end
      DRAIN: begin
        state_s = DRAIN;
      end
      WRITE: begin
        mem_en_s    = 1'b1;
        mem_wr_s    = 1'b1;
        mem_addr_s  = bus.st_addr;
        mem_wdata_s = bus.st_data;
        st_ack_s    = 1'b1;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (ret_s) begin
      ret_cnt_s = ret_cnt_r + CW'(1);
      if (last_ret_s) begin
        state_s = IDLE;
      end else begin
        state_s = state_s;
      end
    end else begin
      ret_cnt_s = ret_cnt_s;
    end
  end

  // State, ownership and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= OWNER_I;
      last_fill_r <= OWNER_D;
      base_r      <= '0;
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
      mem_en_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      st_ack_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      last_fill_r <= last_fill_s;
      base_r      <= base_s;
      issue_cnt_r <= issue_cnt_s;
      ret_cnt_r   <= ret_cnt_s;
      mem_en_r    <= mem_en_s;
      mem_wr_r    <= mem_wr_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      st_ack_r    <= st_ack_s;
    end
  end

  // Fill strobes must align with the pass-through data, so they decode the live return.
  assign bus.i_fill_we = ret_s && (owner_r == OWNER_I);
  assign bus.d_fill_we = ret_s && (owner_r == OWNER_D);
  assign bus.i_tag_we  = last_ret_s && (owner_r == OWNER_I);
  assign bus.d_tag_we  = last_ret_s && (owner_r == OWNER_D);
  assign bus.fill_word = ret_cnt_r;
  assign bus.fill_data = bus.mem_data_in;

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.st_ack    = st_ack_r;
  assign bus.busy      = busy_s;

  assign bus.i_stall = bus.i_miss_req |
                       (busy_s & (owner_r == OWNER_I) & (state_r != WRITE));
  assign bus.d_stall = bus.d_miss_req | (bus.st_req & ~st_ack_r) |
                       (busy_s & (owner_r == OWNER_D) & (state_r != WRITE));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a fixed 4-cycle-latency memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    bit          is_d;
    logic [2:0]  word;
    logic [15:0] data;
    bit          tag;
    int          cyc;
  } fill_exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } ret_t;

  mem_exp_t  exp_mem[$];
  fill_exp_t exp_fill[$];
  ret_t      ret_q[$];

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Grant edge t: reads visible t+1.., fill writes t+5.., tag on word 7.
  task automatic push_fill(input bit is_d, input logic [15:0] base, input int t,
                           input int nread, input int nfill);
    for (int k = 0; k < nread; k++)
      exp_mem.push_back('{1'b0, base + 16'(2 * k), 16'h0000, t + 1 + k});
    for (int k = 0; k < nfill; k++)
      exp_fill.push_back('{is_d, 3'(k), mem_val(base + 16'(2 * k)), (k == 7), t + 5 + k});
  endtask

  task automatic chk_status(input string tag, input logic busy, input logic is, input logic ds);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, "_i_stall"}, 32'(bus.i_stall), 32'(is));
    chk({tag, "_d_stall"}, 32'(bus.d_stall), 32'(ds));
  endtask

  // Memory model: a read seen in cycle c returns its data in cycle c+4.
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0)
      ret_q.push_back('{cyc + 4, mem_val(bus.mem_addr)});
  end

  always @(posedge clk) begin
    #1;
    if (ret_q.size() > 0 && ret_q[0].cyc == cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data_in    = 16'h0000;
    end
  end

  // Scoreboard monitor: every memory command and every fill write pops the next expectation.
  always @(negedge clk) begin
    mem_exp_t  me;
    fill_exp_t fe;
    if (bus.mem_en === 1'b1) begin
      if (exp_mem.size() == 0) begin
        chk("mem_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        me = exp_mem.pop_front();
        chk("mem_cyc", 32'(cyc), 32'(me.cyc));
        chk("mem_wr", 32'(bus.mem_wr), 32'(me.wr));
        chk("mem_addr", 32'(bus.mem_addr), 32'(me.addr));
        if (me.wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(me.wdata));
        chk("st_ack", 32'(bus.st_ack), 32'(me.wr));
      end
    end else if (bus.st_ack === 1'b1) begin
      chk("st_ack_alone", 32'(bus.st_ack), 32'd0);
    end
    if ((bus.i_fill_we | bus.d_fill_we | bus.i_tag_we | bus.d_tag_we) === 1'b1) begin
      if (exp_fill.size() == 0) begin
        chk("fill_unexpected", 32'({bus.i_fill_we, bus.d_fill_we, bus.i_tag_we, bus.d_tag_we}), 32'd0);
      end else begin
        fe = exp_fill.pop_front();
        chk("fill_cyc", 32'(cyc), 32'(fe.cyc));
        chk("fill_we", 32'({bus.i_fill_we, bus.d_fill_we}), fe.is_d ? 32'd1 : 32'd2);
        chk("tag_we", 32'({bus.i_tag_we, bus.d_tag_we}),
            fe.tag ? (fe.is_d ? 32'd1 : 32'd2) : 32'd0);
        chk("fill_word", 32'(bus.fill_word), 32'(fe.word));
        chk("fill_data", 32'(bus.fill_data), 32'(fe.data));
      end
    end
  end

  initial begin
    bus.i_miss_req     = 1'b0;
    bus.i_miss_addr    = 16'h0000;
    bus.d_miss_req     = 1'b0;
    bus.d_miss_addr    = 16'h0000;
    bus.st_req         = 1'b0;
    bus.st_addr        = 16'h0000;
    bus.st_data        = 16'h0000;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = 16'h0000;

    // Reset state
    at_cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_st_ack", 32'(bus.st_ack), 32'd0);
    chk("rst_stalls", 32'({bus.i_stall, bus.d_stall}), 32'd0);
    chk("rst_we", 32'({bus.i_fill_we, bus.d_fill_we, bus.i_tag_we, bus.d_tag_we}), 32'd0);

    // Simultaneous I and D misses after reset: I first, D right after
    at_cyc(5);
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h200A;
    bus.d_miss_req = 1'b1; bus.d_miss_addr = 16'h4006;
    push_fill(1'b0, 16'h2000, 6, 8, 8);
    push_fill(1'b1, 16'h4000, 20, 8, 8);
    chk_status("tie_req", 1'b0, 1'b1, 1'b1);
    at_cyc(10); chk_status("tie_ifill", 1'b1, 1'b1, 1'b1);
    at_cyc(18); bus.i_miss_req = 1'b0;
    at_cyc(19); chk_status("tie_gap", 1'b0, 1'b0, 1'b1);
    at_cyc(22); chk_status("tie_dfill", 1'b1, 1'b0, 1'b1);
    at_cyc(32); bus.d_miss_req = 1'b0;
    at_cyc(33); chk_status("tie_done", 1'b0, 1'b0, 1'b0);

    // Lone I miss at 0x1236, requester drops mid-fill
    at_cyc(35);
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h1236;
    push_fill(1'b0, 16'h1230, 36, 8, 8);
    at_cyc(38); bus.i_miss_req = 1'b0;
    at_cyc(39); chk_status("imiss_drop", 1'b1, 1'b1, 1'b0);
    at_cyc(49); chk_status("imiss_done", 1'b0, 1'b0, 1'b0);

    // Both held continuously: fills alternate D, I, D (last fill was I)
    at_cyc(52);
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h7F1E;
    bus.d_miss_req = 1'b1; bus.d_miss_addr = 16'h5554;
    push_fill(1'b1, 16'h5550, 53, 8, 8);
    push_fill(1'b0, 16'h7F10, 67, 8, 8);
    push_fill(1'b1, 16'h5550, 81, 8, 8);
    at_cyc(94);
    bus.i_miss_req = 1'b0;
    bus.d_miss_req = 1'b0;
    at_cyc(95); chk_status("alt_done", 1'b0, 1'b0, 1'b0);

    // Lone store
    at_cyc(97);
    bus.st_req = 1'b1; bus.st_addr = 16'h0040; bus.st_data = 16'hBEEF;
    exp_mem.push_back('{1'b1, 16'h0040, 16'hBEEF, 99});
    chk_status("st_req", 1'b0, 1'b0, 1'b1);
    at_cyc(98); chk_status("st_write", 1'b1, 1'b0, 1'b1);
    at_cyc(99); chk_status("st_ack", 1'b0, 1'b0, 1'b0);
    at_cyc(100); bus.st_req = 1'b0;

    // Store plus D miss: the fill goes first, the store follows
    at_cyc(102);
    bus.st_req = 1'b1; bus.st_addr = 16'h0082; bus.st_data = 16'h1234;
    bus.d_miss_req = 1'b1; bus.d_miss_addr = 16'h3338;
    push_fill(1'b1, 16'h3330, 103, 8, 8);
    exp_mem.push_back('{1'b1, 16'h0082, 16'h1234, 118});
    at_cyc(115); bus.d_miss_req = 1'b0;
    at_cyc(116); chk_status("stm_idle", 1'b0, 1'b0, 1'b1);
    at_cyc(117); chk_status("stm_write", 1'b1, 1'b0, 1'b1);
    at_cyc(118); bus.st_req = 1'b0;

    // Reset at T+7 of a fill: late returns must be ignored
    at_cyc(121);
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h0A00;
    push_fill(1'b0, 16'h0A00, 122, 7, 3);
    at_cyc(129);
    rst = 1'b1;
    bus.i_miss_req = 1'b0;
    at_cyc(130);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_mem_en", 32'(bus.mem_en), 32'd0);
    at_cyc(134); chk_status("rstmid_late", 1'b0, 1'b0, 1'b0);

    at_cyc(140);
    @(negedge clk);
    chk("exp_mem_left", 32'(exp_mem.size()), 32'd0);
    chk("exp_fill_left", 32'(exp_fill.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
